writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath and register width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, meaning register-index width (32 registers).
REQ-003 SHALL have port i_clk  input  1  meaning the only clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port i_valid  input  1  meaning the memory-stage result on i_data is valid this cycle.
REQ-006 SHALL have port i_data  input  DATA_W  meaning the memory-stage result (ALU value or load data, already selected).
REQ-007 SHALL have port i_regWrite  input  1  meaning the instruction writes a register.
REQ-008 SHALL have port i_rd  input  REG_ADDR_W  meaning the destination register index.
REQ-009 SHALL have port i_stall  input  1  meaning hold the stage: no capture, no commit.
REQ-010 SHALL have port i_flush  input  1  meaning squash the incoming entry.
REQ-011 SHALL have ports i_rs and i_rt  input  REG_ADDR_W  meaning the read addresses.
REQ-012 SHALL have ports o_rs_data and o_rt_data  output  DATA_W  meaning the read data.
REQ-013 SHALL have ports o_wb_valid (1), o_wb_rd (REG_ADDR_W) and o_wb_data (DATA_W)  output  meaning the held entry, exported for forwarding.
REQ-014 SHALL have port o_retire_cnt  output  32  meaning the number of committed entries.

Function
REQ-015 SHALL hold one stage entry: valid_q, data_q, rd_q, regWrite_q; o_wb_valid, o_wb_rd and o_wb_data SHALL be these registers directly.
REQ-016 With i_stall=0 at a rising edge, SHALL capture valid_q<=i_valid&~i_flush, together with data_q, rd_q and regWrite_q.
REQ-017 With i_stall=1, SHALL hold all stage registers, ignore i_flush, perform no commit and leave the counter unchanged.
REQ-018 Commit occurs at an edge where valid_q=1 and i_stall=0; capture of the next entry SHALL occur on that same edge (latency: one cycle from capture to commit, barring stalls).
REQ-019 On commit with regWrite_q=1 and rd_q!=0, SHALL write data_q to register rd_q.
REQ-020 SHALL never write register 0, and reads of index 0 SHALL always return 0.
REQ-021 On every commit, SHALL increment o_retire_cnt by 1 regardless of regWrite_q, wrapping from 0xFFFFFFFF to 0.
REQ-022 Reads SHALL be combinational from the register array; a read at the same address as a commit in the same cycle returns the old value (unless the bypass of REQ-026 is compiled in).
REQ-023 An entry with valid_q=0 SHALL neither write nor count, whatever regWrite_q holds.

Reset
REQ-024 When i_rst is asserted, SHALL immediately (asynchronously) clear valid_q, data_q, rd_q, regWrite_q, o_retire_cnt and all 32 registers to 0.
REQ-025 Reset during a pending entry SHALL discard that entry without a commit; the first capture occurs at the first rising edge after i_rst deasserts.

Configuration
REQ-026 Macro WB_BYPASS_EN: when defined, a read whose address equals rd_q (nonzero) during a commit cycle with regWrite_q=1 SHALL return data_q; when undefined, reads SHALL return array contents only, per REQ-022.

Structure
REQ-027 Package mips_pkg SHALL hold DATA_W, REG_ADDR_W, the REG_ZERO index constant and the reset value 0.
REQ-028 The register array SHALL be the sub-module regfile (2 read ports, 1 write port, async reset); the stage register, commit logic and counter SHALL live in writeback_stage.

Verification
REQ-029 The bench SHALL cover: i_valid=1, i_regWrite=1, i_rd=5, i_data=0xDEADBEEF, then one idle cycle -> i_rs=5 reads 0xDEADBEEF; o_retire_cnt=1.
REQ-030 The bench SHALL cover: i_rd=0, i_data=0x1234 with a commit -> i_rs=0 reads 0; o_retire_cnt increments.
REQ-031 The bench SHALL cover: entry to r7 with i_stall=1 held for 3 cycles -> r7 is unchanged and the count is unchanged; on release, one commit and the count increments exactly once.
REQ-032 The bench SHALL cover: i_valid=1, i_flush=1, i_stall=0, i_rd=9 -> valid_q=0; r9 is not written and the count is unchanged.
REQ-033 The bench SHALL cover: commit to r3 of 0xA5A5A5A5 with i_rs=3 in the commit cycle -> 0xA5A5A5A5 with WB_BYPASS_EN, the old r3 value without it.
REQ-034 The bench SHALL cover: counter preloaded near wrap with 0xFFFFFFFF, then one commit -> 0; i_rst pulsed mid-entry -> all outputs 0 and the entry is not committed.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
//
// Shared constants for the MIPS-style writeback slice.
//
//   DATA_W      default datapath / register width
//   REG_ADDR_W  default register-index width (2**REG_ADDR_W registers)
//   NUM_REGS    number of architectural registers at the default width
//   REG_ZERO    index of the hardwired-zero register
//   RST_VAL     value every state element takes while reset is asserted
//
// REG_ZERO and RST_VAL are plain integers. Each user sizes them to its own
// parameterised width with a cast, so the package never fixes a datapath width.
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned RST_VAL  = 0;

endpackage : mips_pkg

// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile
//
// General-purpose register array. It has two combinational read ports and one
// synchronous write port. Register REG_ZERO is hardwired to zero: writes to it
// are dropped, and reads of it return zero.
//
// Parameters
//   DATA_W      register width
//   ADDR_W      index width; the array holds 2**ADDR_W registers
//
// Ports
//   i_clk       clock; the write port updates on the rising edge
//   i_rst       asynchronous active-high reset; clears every register
//   i_we        write enable
//   i_waddr     write index
//   i_wdata     write data
//   i_raddr_a   read index, port A
//   o_rdata_a   read data, port A (array contents, old value on same-cycle write)
//   i_raddr_b   read index, port B
//   o_rdata_b   read data, port B
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(mips_pkg::REG_ZERO);
  localparam logic [DATA_W-1:0] RST_WORD = DATA_W'(mips_pkg::RST_VAL);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // NOTE: this array really does need its reset. Software relies on every
  // register reading zero after reset, so it cannot be mapped onto a RAM
  // macro without reset. Storage without a reset would drop the loop below.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RST_WORD;
      end
    end else if (i_we && (i_waddr != ZERO_IDX)) begin
      regs[i_waddr] <= i_wdata;
    end
  end

  // Register zero never receives a write, so it always holds zero.
  // The read mux still forces zero for that index. The result then does not
  // depend on what the register happens to store.
  assign o_rdata_a = (i_raddr_a == ZERO_IDX) ? RST_WORD : regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == ZERO_IDX) ? RST_WORD : regs[i_raddr_b];

endmodule : regfile

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
//
// Final pipeline stage. It holds one entry captured from the memory stage. On
// the following unstalled edge the entry commits into the register file, and
// the next entry is captured on that same edge. Every committed entry is
// counted in o_retire_cnt, whether or not it writes a register.
//
// Optional feature
//   WB_BYPASS_EN  when defined, a read whose index equals the committing
//                 destination (nonzero, regWrite set) returns the committing
//                 data instead of the old array contents.
//
// Parameters
//   DATA_W        datapath and register width
//   REG_ADDR_W    register-index width
//
// Ports
//   i_clk         clock; all state updates on the rising edge
//   i_rst         asynchronous active-high reset
//   i_valid       memory-stage result valid this cycle
//   i_data        memory-stage result (ALU value or load data)
//   i_regWrite    instruction writes a register
//   i_rd          destination register index
//   i_stall       hold the stage: no capture, no commit, counter frozen
//   i_flush       squash the incoming entry (ignored while stalled)
//   i_rs, i_rt    register read indices
//   o_rs_data     read data for i_rs
//   o_rt_data     read data for i_rt
//   o_wb_valid    held entry valid     (for forwarding)
//   o_wb_rd       held entry rd        (for forwarding)
//   o_wb_data     held entry data      (for forwarding)
//   o_retire_cnt  number of committed entries, wraps modulo 2**32
// -----------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_W     = mips_pkg::DATA_W,
  parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_W-1:0]     i_data,
  input  logic                  i_regWrite,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic [REG_ADDR_W-1:0] i_rt,
  output logic [DATA_W-1:0]     o_rs_data,
  output logic [DATA_W-1:0]     o_rt_data,
  output logic                  o_wb_valid,
  output logic [REG_ADDR_W-1:0] o_wb_rd,
  output logic [DATA_W-1:0]     o_wb_data,
  output logic [31:0]           o_retire_cnt
);

  localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(mips_pkg::REG_ZERO);
  localparam logic [DATA_W-1:0]     RST_WORD = DATA_W'(mips_pkg::RST_VAL);
  localparam logic [31:0]           RST_CNT  = 32'(mips_pkg::RST_VAL);

  // ---------------------------------------------------------------------------
  // Stage entry
  // ---------------------------------------------------------------------------
  logic                  valid_q;
  logic [DATA_W-1:0]     data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  regwrite_q;
  logic [31:0]           retire_cnt_q;

  // NOTE: state registers use non-blocking assignments only. Every flop then
  // samples the values from before the edge, so commit, which reads the old
  // entry, and capture, which loads the new one, can share a single edge
  // with no ordering hazard.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q    <= 1'b0;
      data_q     <= RST_WORD;
      rd_q       <= ZERO_IDX;
      regwrite_q <= 1'b0;
    end else if (!i_stall) begin
      // A flush squashes only the valid bit. The payload is still loaded but
      // stays inert, because nothing commits an entry with valid_q low.
      valid_q    <= i_valid & ~i_flush;
      data_q     <= i_data;
      rd_q       <= i_rd;
      regwrite_q <= i_regWrite;
    end
  end

  // ---------------------------------------------------------------------------
  // Commit
  // ---------------------------------------------------------------------------
  // The held entry retires on the next edge unless the stage is stalled.
  // A retiring entry writes a register only when it asks to, and never
  // writes register zero.
  logic commit;
  logic rf_we;

  assign commit = valid_q & ~i_stall;
  assign rf_we  = commit & regwrite_q & (rd_q != ZERO_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      retire_cnt_q <= RST_CNT;
    end else if (commit) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (REG_ADDR_W)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (rf_we),
    .i_waddr   (rd_q),
    .i_wdata   (data_q),
    .i_raddr_a (i_rs),
    .o_rdata_a (rf_rs_data),
    .i_raddr_b (i_rt),
    .o_rdata_b (rf_rt_data)
  );

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
`ifdef WB_BYPASS_EN
  // rf_we already excludes register zero and non-writing entries. A match on
  // it therefore means the array is about to take data_q at this index.
  always_comb begin
    o_rs_data = rf_rs_data;
    o_rt_data = rf_rt_data;
    if (rf_we && (i_rs == rd_q)) o_rs_data = data_q;
    if (rf_we && (i_rt == rd_q)) o_rt_data = data_q;
  end
`else
  // Without the bypass, a same-cycle read returns the value from before the
  // commit. Forwarding is left to o_wb_* consumers.
  assign o_rs_data = rf_rs_data;
  assign o_rt_data = rf_rt_data;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_wb_valid   = valid_q;
  assign o_wb_rd      = rd_q;
  assign o_wb_data    = data_q;
  assign o_retire_cnt = retire_cnt_q;

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
//
// Directed bench for writeback_stage. A table of single-cycle vectors carries
// hand-computed expectations. Hand-written sequences then cover stall hold,
// bypass behaviour, counter wrap and mid-entry reset.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          i_regWrite;
  logic [AW-1:0] i_rd;
  logic          i_stall;
  logic          i_flush;
  logic [AW-1:0] i_rs;
  logic [AW-1:0] i_rt;
  logic [DW-1:0] o_rs_data;
  logic [DW-1:0] o_rt_data;
  logic          o_wb_valid;
  logic [AW-1:0] o_wb_rd;
  logic [DW-1:0] o_wb_data;
  logic [31:0]   o_retire_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  writeback_stage #(
    .DATA_W     (DW),
    .REG_ADDR_W (AW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_regWrite   (i_regWrite),
    .i_rd         (i_rd),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_rs         (i_rs),
    .i_rt         (i_rt),
    .o_rs_data    (o_rs_data),
    .o_rt_data    (o_rt_data),
    .o_wb_valid   (o_wb_valid),
    .o_wb_rd      (o_wb_rd),
    .o_wb_data    (o_wb_data),
    .o_retire_cnt (o_retire_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          valid;
    logic          regwrite;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          stall;
    logic          flush;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          exp_wb_valid;
    logic [AW-1:0] exp_wb_rd;
    logic [DW-1:0] exp_wb_data;
    logic [DW-1:0] exp_rs;
    logic [DW-1:0] exp_rt;
    logic [31:0]   exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [AW-1:0] rd,
                       input logic [DW-1:0] d, input logic st, input logic fl);
    i_valid    = v;
    i_regWrite = rw;
    i_rd       = rd;
    i_data     = d;
    i_stall    = st;
    i_flush    = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(
    input logic v, input logic rw, input logic [AW-1:0] rd, input logic [DW-1:0] d,
    input logic st, input logic fl, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
    input logic ewv, input logic [AW-1:0] ewr, input logic [DW-1:0] ewd,
    input logic [DW-1:0] ers, input logic [DW-1:0] ert, input logic [31:0] ec);
    vec_t r;
    r.valid = v;  r.regwrite = rw; r.rd = rd; r.data = d; r.stall = st; r.flush = fl;
    r.rs = rs;    r.rt = rt;
    r.exp_wb_valid = ewv; r.exp_wb_rd = ewr; r.exp_wb_data = ewd;
    r.exp_rs = ers; r.exp_rt = ert; r.exp_cnt = ec;
    return r;
  endfunction

  logic [DW-1:0] exp_bypass;

  initial begin
    // Each row is applied for one edge, and the expectations hold just after it.
    //        v  rw rd     data          st fl rs     rt     wbv wbrd   wbdata        rs            rt            cnt
    vecs[0] = mk(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, 5'd0, 5'd1, 1, 5'd5, 32'hDEADBEEF, 32'h0,        32'h0,        32'd0);
    vecs[1] = mk(0, 0, 5'd0, 32'h0,        0, 0, 5'd5, 5'd0, 0, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        32'd1);
    vecs[2] = mk(1, 1, 5'd0, 32'h1234,     0, 0, 5'd5, 5'd0, 1, 5'd0, 32'h1234,     32'hDEADBEEF, 32'h0,        32'd1);
    vecs[3] = mk(0, 0, 5'd0, 32'h0,        0, 0, 5'd0, 5'd5, 0, 5'd0, 32'h0,        32'h0,        32'hDEADBEEF, 32'd2);
    vecs[4] = mk(1, 0, 5'd6, 32'h55,       0, 0, 5'd6, 5'd5, 1, 5'd6, 32'h55,       32'h0,        32'hDEADBEEF, 32'd2);
    vecs[5] = mk(1, 1, 5'd8, 32'h808,      0, 0, 5'd6, 5'd0, 1, 5'd8, 32'h808,      32'h0,        32'h0,        32'd3);
    vecs[6] = mk(0, 0, 5'd0, 32'h0,        0, 0, 5'd8, 5'd6, 0, 5'd0, 32'h0,        32'h808,      32'h0,        32'd4);
    vecs[7] = mk(1, 1, 5'd9, 32'h99,       0, 1, 5'd9, 5'd8, 0, 5'd9, 32'h99,       32'h0,        32'h808,      32'd4);
    vecs[8] = mk(0, 0, 5'd0, 32'h0,        0, 0, 5'd9, 5'd8, 0, 5'd0, 32'h0,        32'h0,        32'h808,      32'd4);

    // ---- reset state ----
    i_rst = 1'b1;
    idle();
    i_rs = 5'd5;
    i_rt = 5'd31;
    repeat (2) step();
    check("reset_wb_valid", 32'(o_wb_valid), 32'd0);
    check("reset_wb_data",  o_wb_data,       32'd0);
    check("reset_cnt",      o_retire_cnt,    32'd0);
    check("reset_rt31",     o_rt_data,       32'd0);
    i_rst = 1'b0;

    // ---- table-driven vectors ----
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].valid, vecs[i].regwrite, vecs[i].rd, vecs[i].data, vecs[i].stall, vecs[i].flush);
      i_rs = vecs[i].rs;
      i_rt = vecs[i].rt;
      step();
      check($sformatf("vec%0d_wb_valid", i), 32'(o_wb_valid), 32'(vecs[i].exp_wb_valid));
      check($sformatf("vec%0d_wb_rd", i),    32'(o_wb_rd),    32'(vecs[i].exp_wb_rd));
      check($sformatf("vec%0d_wb_data", i),  o_wb_data,       vecs[i].exp_wb_data);
      check($sformatf("vec%0d_rs", i),       o_rs_data,       vecs[i].exp_rs);
      check($sformatf("vec%0d_rt", i),       o_rt_data,       vecs[i].exp_rt);
      check($sformatf("vec%0d_cnt", i),      o_retire_cnt,    vecs[i].exp_cnt);
    end

    // ---- stall holds entry to r7 for 3 cycles ----
    drive(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b0);
    i_rs = 5'd7;
    i_rt = 5'd0;
    step();
    check("stall_capture", 32'(o_wb_valid), 32'd1);
    // New inputs and a flush are both presented during the stall and must be ignored.
    drive(1'b1, 1'b1, 5'd12, 32'hBAD, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall%0d_r7", k),    o_rs_data,       32'h0);
      check($sformatf("stall%0d_cnt", k),   o_retire_cnt,    32'd4);
      check($sformatf("stall%0d_valid", k), 32'(o_wb_valid), 32'd1);
      check($sformatf("stall%0d_rd", k),    32'(o_wb_rd),    32'd7);
    end
    idle();
    step();
    check("stall_release_r7",  o_rs_data,       32'h77);
    check("stall_release_cnt", o_retire_cnt,    32'd5);
    check("stall_release_vld", 32'(o_wb_valid), 32'd0);
    step();
    check("stall_once_cnt",    o_retire_cnt,    32'd5);

    // ---- same-cycle read of a committing register ----
    drive(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
    i_rs = 5'd0;
    step();
    idle();
    step();
    i_rs = 5'd3;
    #1;
    check("r3_old", o_rs_data, 32'h11);
    check("r3_old_cnt", o_retire_cnt, 32'd6);
    drive(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
    step();
    idle();
    #1;
`ifdef WB_BYPASS_EN
    exp_bypass = 32'hA5A5A5A5;
`else
    exp_bypass = 32'h11;
`endif
    check("r3_commit_cycle_read", o_rs_data, exp_bypass);
    step();
    check("r3_after_commit", o_rs_data,    32'hA5A5A5A5);
    check("r3_commit_cnt",   o_retire_cnt, 32'd7);

    // ---- counter wrap ----
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    check("wrap_preload", o_retire_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 5'd4, 32'h44, 1'b0, 1'b0);
    step();
    check("wrap_pending", o_retire_cnt, 32'hFFFF_FFFF);
    idle();
    step();
    check("wrap_zero", o_retire_cnt, 32'd0);

    // ---- reset during a pending entry ----
    drive(1'b1, 1'b1, 5'd10, 32'hCAFE, 1'b0, 1'b0);
    i_rs = 5'd10;
    i_rt = 5'd5;
    step();
    check("rst_pending_valid", 32'(o_wb_valid), 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(o_wb_valid),   32'd0);
    check("rst_async_rd",    32'(o_wb_rd),      32'd0);
    check("rst_async_data",  o_wb_data,         32'd0);
    check("rst_async_cnt",   o_retire_cnt,      32'd0);
    check("rst_async_r5",    o_rt_data,         32'd0);
    step();
    i_rst = 1'b0;
    idle();
    step();
    check("rst_no_commit_r10", o_rs_data,    32'd0);
    check("rst_no_commit_cnt", o_retire_cnt, 32'd0);
    drive(1'b1, 1'b1, 5'd10, 32'h1010, 1'b0, 1'b0);
    step();
    check("post_rst_capture", 32'(o_wb_valid), 32'd1);
    idle();
    step();
    check("post_rst_r10", o_rs_data,    32'h1010);
    check("post_rst_cnt", o_retire_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guards against a stuck simulation. It should never trigger.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_writeback_stage
